// File: rtl/types_pkg.sv
// Shared type definitions for the encryption engine and the hash generator
// it draws keystream bytes from.
package types_pkg;

   // Status reported by the hash generator; only H_GROUND and H_READY
   // mean a byte request will be honoured.
   typedef enum logic [1:0] {
      H_GROUND = 2'd0,
      H_BUSY   = 2'd1,
      H_READY  = 2'd2,
      H_FAULT  = 2'd3
   } hash_generator_state_t;

   typedef enum logic [1:0] {
      ENG_IDLE    = 2'd0,
      ENG_REQUEST = 2'd1,
      ENG_AWAIT   = 2'd2,
      ENG_EMIT    = 2'd3
   } encryption_engine_state_t;

   function automatic logic hash_can_serve(input hash_generator_state_t s);
      return (s == H_GROUND) || (s == H_READY);
   endfunction

endpackage

// File: rtl/cipher_word_fifo.sv
// Plaintext word FIFO. A push while full is accepted only if a pop happens
// in the same cycle; pointers wrap naturally because DEPTH is a power of two.
module cipher_word_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         nrst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign full      = (r_count == CW'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign pop_data  = r_mem[r_rd_ptr];
   assign w_pop_ok  = pop && !empty;
   assign w_push_ok = push && (!full || w_pop_ok);

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/encryption_engine.sv
// Word-level stream cipher: queues plaintext words, fetches one keystream
// byte per data byte from the hash generator, XORs them in and emits the
// ciphertext word. Bypassed words skip the keystream entirely.
module encryption_engine
   import types_pkg::*;
#(
   parameter int WORD_BYTES = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              nrst,
   input  logic [8*WORD_BYTES-1:0]           word_in,
   input  logic                              word_in_pulse,
   input  logic                              bypass,
   input  hash_generator_state_t             hash_generator_state,
   output logic                              request_byte_pulse_out,
   input  logic [7:0]                        hash_byte,
   input  logic                              hash_byte_pulse,
   output logic [8*WORD_BYTES-1:0]           word_out,
   output logic                              word_pulse_out,
   output logic                              fifo_full_out,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_out,
   output logic                              overflow_out,
   output encryption_engine_state_t          engine_state_out
);

   localparam int W  = 8 * WORD_BYTES;
   localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

   encryption_engine_state_t r_state;
   encryption_engine_state_t w_next;

   logic [W-1:0]  r_work;
   logic [IW-1:0] r_idx;
   logic [W-1:0]  r_word_out;
   logic          r_req;
   logic          r_word_pulse;
   logic          r_overflow;

   logic          w_pop;
   logic          w_req_fire;
   logic          w_hash_take;
   logic          w_emit;
   logic          w_last_byte;
   logic          w_full;
   logic          w_empty;
   logic          w_drop;
   logic [W-1:0]  w_fifo_data;

   cipher_word_fifo #(
      .WIDTH (W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .nrst      (nrst),
      .push      (word_in_pulse),
      .push_data (word_in),
      .pop       (w_pop),
      .pop_data  (w_fifo_data),
      .full      (w_full),
      .empty     (w_empty),
      .count     (fifo_count_out)
   );

   assign w_last_byte = (r_idx == IW'(WORD_BYTES - 1));
   assign w_drop      = word_in_pulse && w_full && !w_pop;

   // State register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_state <= ENG_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic and single-cycle control strobes.
   always_comb begin
      w_next      = r_state;
      w_pop       = 1'b0;
      w_req_fire  = 1'b0;
      w_hash_take = 1'b0;
      w_emit      = 1'b0;
      case (r_state)
         ENG_IDLE: begin
            if (!w_empty) begin
               w_pop  = 1'b1;
               w_next = bypass ? ENG_EMIT : ENG_REQUEST;
            end
         end
         ENG_REQUEST: begin
            if (hash_can_serve(hash_generator_state)) begin
               w_req_fire = 1'b1;
               w_next     = ENG_AWAIT;
            end
         end
         ENG_AWAIT: begin
            if (hash_byte_pulse) begin
               w_hash_take = 1'b1;
               w_next      = w_last_byte ? ENG_EMIT : ENG_REQUEST;
            end
         end
         ENG_EMIT: begin
            w_emit = 1'b1;
            w_next = ENG_IDLE;
         end
         default: w_next = ENG_IDLE;
      endcase
   end

   // Working register, byte index, registered outputs and sticky overflow.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_work       <= '0;
         r_idx        <= '0;
         r_word_out   <= '0;
         r_req        <= 1'b0;
         r_word_pulse <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_req        <= w_req_fire;
         r_word_pulse <= w_emit;
         if (w_drop) r_overflow <= 1'b1;
         if (w_pop) begin
            r_work <= w_fifo_data;
            r_idx  <= '0;
         end
         if (w_hash_take) begin
            for (int unsigned b = 0; b < WORD_BYTES; b++) begin
               if (r_idx == IW'(b)) r_work[8*b +: 8] <= r_work[8*b +: 8] ^ hash_byte;
            end
            if (!w_last_byte) r_idx <= r_idx + IW'(1);
         end
         if (w_emit) r_word_out <= r_work;
      end
   end

   assign request_byte_pulse_out = r_req;
   assign word_out               = r_word_out;
   assign word_pulse_out         = r_word_pulse;
   assign fifo_full_out          = w_full;
   assign overflow_out           = r_overflow;
   assign engine_state_out       = r_state;

endmodule

// File: tb/tb_encryption_engine.sv
// Directed testbench for encryption_engine (WORD_BYTES=2, FIFO_DEPTH=4).
module tb_encryption_engine;
   import types_pkg::*;

   logic                     clk;
   logic                     nrst;
   logic [15:0]              word_in;
   logic                     word_in_pulse;
   logic                     bypass;
   hash_generator_state_t    hash_generator_state;
   logic                     request_byte_pulse_out;
   logic [7:0]               hash_byte;
   logic                     hash_byte_pulse;
   logic [15:0]              word_out;
   logic                     word_pulse_out;
   logic                     fifo_full_out;
   logic [2:0]               fifo_count_out;
   logic                     overflow_out;
   encryption_engine_state_t engine_state_out;

   int n_cmp = 0;
   int n_bad = 0;
   int req_cnt = 0;
   int wp_cnt = 0;

   encryption_engine #(
      .WORD_BYTES (2),
      .FIFO_DEPTH (4)
   ) dut (
      .clk                    (clk),
      .nrst                   (nrst),
      .word_in                (word_in),
      .word_in_pulse          (word_in_pulse),
      .bypass                 (bypass),
      .hash_generator_state   (hash_generator_state),
      .request_byte_pulse_out (request_byte_pulse_out),
      .hash_byte              (hash_byte),
      .hash_byte_pulse        (hash_byte_pulse),
      .word_out               (word_out),
      .word_pulse_out         (word_pulse_out),
      .fifo_full_out          (fifo_full_out),
      .fifo_count_out         (fifo_count_out),
      .overflow_out           (overflow_out),
      .engine_state_out       (engine_state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (request_byte_pulse_out === 1'b1) req_cnt++;
      if (word_pulse_out === 1'b1) wp_cnt++;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [15:0] w);
      word_in = w;
      word_in_pulse = 1'b1;
      tick(1);
      word_in_pulse = 1'b0;
   endtask

   task automatic reply(input logic [7:0] b);
      hash_byte = b;
      hash_byte_pulse = 1'b1;
      tick(1);
      hash_byte_pulse = 1'b0;
      hash_byte = 8'h00;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (request_byte_pulse_out === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_word(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (word_pulse_out === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Serve both keystream bytes of one word and wait for its output pulse.
   task automatic serve_word(input logic [7:0] k0, input logic [7:0] k1, output bit ok);
      bit a, b, c;
      wait_req(a);
      if (a) reply(k0);
      wait_req(b);
      if (b) reply(k1);
      wait_word(c);
      ok = a && b && c;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      word_in = '0;
      word_in_pulse = 1'b0;
      bypass = 1'b0;
      hash_generator_state = H_BUSY;
      hash_byte = '0;
      hash_byte_pulse = 1'b0;
      tick(3);
      nrst = 1'b1;
      tick(1);
      n_cmp++; if (word_out !== 16'h0000) begin n_bad++; $display("FAIL reset_word_out got %h want 0000", word_out); end
      n_cmp++; if (word_pulse_out !== 1'b0) begin n_bad++; $display("FAIL reset_word_pulse got %b want 0", word_pulse_out); end
      n_cmp++; if (request_byte_pulse_out !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", request_byte_pulse_out); end
      n_cmp++; if (fifo_full_out !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", fifo_full_out); end
      n_cmp++; if (fifo_count_out !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", fifo_count_out); end
      n_cmp++; if (overflow_out !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow_out); end
      n_cmp++; if (engine_state_out !== ENG_IDLE) begin n_bad++; $display("FAIL reset_state got %0d want %0d", engine_state_out, ENG_IDLE); end
   endtask

   task automatic test_basic();
      int base_req, base_wp;
      bit ok;
      hash_generator_state = H_READY;
      bypass = 1'b0;
      base_req = req_cnt;
      base_wp = wp_cnt;
      push(16'hA55A);
      serve_word(8'h0F, 8'hF0, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_timeout got 0 want 1"); end
      n_cmp++; if (word_out !== 16'h5555) begin n_bad++; $display("FAIL basic_word_out got %h want 5555", word_out); end
      tick(2);
      n_cmp++; if (word_pulse_out !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_width got %b want 0", word_pulse_out); end
      n_cmp++; if (req_cnt - base_req !== 2) begin n_bad++; $display("FAIL basic_req_count got %0d want 2", req_cnt - base_req); end
      n_cmp++; if (wp_cnt - base_wp !== 1) begin n_bad++; $display("FAIL basic_word_pulses got %0d want 1", wp_cnt - base_wp); end
      n_cmp++; if (word_out !== 16'h5555) begin n_bad++; $display("FAIL basic_word_hold got %h want 5555", word_out); end
   endtask

   task automatic test_not_ready();
      int base_req;
      bit ok;
      hash_generator_state = H_BUSY;
      base_req = req_cnt;
      push(16'h00FF);
      tick(10);
      n_cmp++; if (req_cnt - base_req !== 0) begin n_bad++; $display("FAIL notready_req_count got %0d want 0", req_cnt - base_req); end
      n_cmp++; if (engine_state_out !== ENG_REQUEST) begin n_bad++; $display("FAIL notready_state got %0d want %0d", engine_state_out, ENG_REQUEST); end
      hash_generator_state = H_READY;
      tick(1);
      n_cmp++; if (request_byte_pulse_out !== 1'b1) begin n_bad++; $display("FAIL notready_req_next got %b want 1", request_byte_pulse_out); end
      reply(8'h11);
      hash_generator_state = H_GROUND;
      wait_req(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL ground_req_timeout got 0 want 1"); end
      reply(8'h22);
      wait_word(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL notready_word_timeout got 0 want 1"); end
      n_cmp++; if (word_out !== 16'h22EE) begin n_bad++; $display("FAIL notready_word_out got %h want 22ee", word_out); end
      tick(2);
   endtask

   task automatic test_overflow();
      logic [15:0] vals [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
      logic [15:0] expv [5] = '{16'hEE11, 16'hDD22, 16'hCC33, 16'hBB44, 16'hAA55};
      bit ok;
      hash_generator_state = H_BUSY;
      n_cmp++; if (overflow_out !== 1'b0) begin n_bad++; $display("FAIL ovf_pre got %b want 0", overflow_out); end
      for (int i = 0; i < 6; i++) begin
         word_in = vals[i];
         word_in_pulse = 1'b1;
         tick(1);
      end
      word_in_pulse = 1'b0;
      n_cmp++; if (fifo_count_out !== 3'd4) begin n_bad++; $display("FAIL ovf_count got %0d want 4", fifo_count_out); end
      n_cmp++; if (fifo_full_out !== 1'b1) begin n_bad++; $display("FAIL ovf_full got %b want 1", fifo_full_out); end
      n_cmp++; if (overflow_out !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow_out); end
      hash_generator_state = H_READY;
      for (int w = 0; w < 5; w++) begin
         serve_word(8'h00, 8'hFF, ok);
         n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovf_timeout_%0d got 0 want 1", w); end
         n_cmp++; if (word_out !== expv[w]) begin n_bad++; $display("FAIL ovf_order_%0d got %h want %h", w, word_out, expv[w]); end
      end
      tick(4);
      n_cmp++; if (fifo_count_out !== 3'd0) begin n_bad++; $display("FAIL ovf_drain_count got %0d want 0", fifo_count_out); end
      n_cmp++; if (engine_state_out !== ENG_IDLE) begin n_bad++; $display("FAIL ovf_drain_state got %0d want %0d", engine_state_out, ENG_IDLE); end
      n_cmp++; if (overflow_out !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", overflow_out); end
   endtask

   task automatic test_bypass();
      int base_req;
      hash_generator_state = H_READY;
      bypass = 1'b1;
      base_req = req_cnt;
      word_in = 16'h1234;
      word_in_pulse = 1'b1;
      @(posedge clk);
      #1;
      word_in_pulse = 1'b0;
      tick(1);
      n_cmp++; if (word_pulse_out !== 1'b0) begin n_bad++; $display("FAIL bypass_early got %b want 0", word_pulse_out); end
      tick(1);
      n_cmp++; if (word_pulse_out !== 1'b1) begin n_bad++; $display("FAIL bypass_latency got %b want 1", word_pulse_out); end
      n_cmp++; if (word_out !== 16'h1234) begin n_bad++; $display("FAIL bypass_word_out got %h want 1234", word_out); end
      tick(1);
      n_cmp++; if (word_pulse_out !== 1'b0) begin n_bad++; $display("FAIL bypass_pulse_width got %b want 0", word_pulse_out); end
      n_cmp++; if (word_out !== 16'h1234) begin n_bad++; $display("FAIL bypass_hold got %h want 1234", word_out); end
      tick(2);
      n_cmp++; if (req_cnt - base_req !== 0) begin n_bad++; $display("FAIL bypass_req_count got %0d want 0", req_cnt - base_req); end
      bypass = 1'b0;
   endtask

   task automatic test_reset_mid();
      int base_req, base_wp;
      bit ok;
      hash_generator_state = H_READY;
      bypass = 1'b0;
      word_in = 16'hBEEF;
      word_in_pulse = 1'b1;
      tick(1);
      word_in = 16'h0101;
      tick(1);
      word_in_pulse = 1'b0;
      wait_req(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_req_timeout got 0 want 1"); end
      n_cmp++; if (engine_state_out !== ENG_AWAIT) begin n_bad++; $display("FAIL rstmid_pre_state got %0d want %0d", engine_state_out, ENG_AWAIT); end
      n_cmp++; if (fifo_count_out !== 3'd1) begin n_bad++; $display("FAIL rstmid_pre_count got %0d want 1", fifo_count_out); end
      nrst = 1'b0;
      #1;
      base_req = req_cnt;
      base_wp = wp_cnt;
      n_cmp++; if (engine_state_out !== ENG_IDLE) begin n_bad++; $display("FAIL rstmid_async_state got %0d want %0d", engine_state_out, ENG_IDLE); end
      n_cmp++; if (fifo_count_out !== 3'd0) begin n_bad++; $display("FAIL rstmid_async_count got %0d want 0", fifo_count_out); end
      n_cmp++; if (word_out !== 16'h0000) begin n_bad++; $display("FAIL rstmid_word_out got %h want 0000", word_out); end
      n_cmp++; if (overflow_out !== 1'b0) begin n_bad++; $display("FAIL rstmid_overflow got %b want 0", overflow_out); end
      tick(2);
      nrst = 1'b1;
      reply(8'h5A);
      tick(10);
      n_cmp++; if (wp_cnt - base_wp !== 0) begin n_bad++; $display("FAIL rstmid_word_pulses got %0d want 0", wp_cnt - base_wp); end
      n_cmp++; if (req_cnt - base_req !== 0) begin n_bad++; $display("FAIL rstmid_req_count got %0d want 0", req_cnt - base_req); end
      n_cmp++; if (engine_state_out !== ENG_IDLE) begin n_bad++; $display("FAIL rstmid_state got %0d want %0d", engine_state_out, ENG_IDLE); end
      n_cmp++; if (fifo_count_out !== 3'd0) begin n_bad++; $display("FAIL rstmid_count got %0d want 0", fifo_count_out); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_not_ready();
      test_overflow();
      test_bypass();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
